// File: rtl/keypad_display_writer.sv
// 4x4 keypad scanner/debouncer that shifts accepted keys into a 4-digit 7-seg entry line.
// Optional build macro KEY_CLEAR_EN: key F blanks all four digits instead of shifting.
module keypad_display_writer #(
  parameter int SCAN_DIV = 50000,
  parameter int DB_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       load,
  output logic [1:0] bufdestino,
  output logic [7:0] datai,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DB_LAST  = 4'(DB_SCANS);

  typedef enum logic       {DB_RELEASED, DB_PRESSED} db_state_t;
  typedef enum logic [1:0] {WR_INIT, WR_IDLE, WR_WRITE} wr_state_t;

  // Matrix position (row*4+col) to hex legend.
  function automatic logic [3:0] key_of(input logic [3:0] idx);
    case (idx)
      4'd0:  key_of = 4'h1;  4'd1:  key_of = 4'h2;  4'd2:  key_of = 4'h3;  4'd3:  key_of = 4'hA;
      4'd4:  key_of = 4'h4;  4'd5:  key_of = 4'h5;  4'd6:  key_of = 4'h6;  4'd7:  key_of = 4'hB;
      4'd8:  key_of = 4'h7;  4'd9:  key_of = 4'h8;  4'd10: key_of = 4'h9;  4'd11: key_of = 4'hC;
      4'd12: key_of = 4'hE;  4'd13: key_of = 4'h0;  4'd14: key_of = 4'hF;  default: key_of = 4'hD;
    endcase
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] code);
    case (code)
      4'h0: seg_of = 8'hC0;  4'h1: seg_of = 8'hF9;  4'h2: seg_of = 8'hA4;  4'h3: seg_of = 8'hB0;
      4'h4: seg_of = 8'h99;  4'h5: seg_of = 8'h92;  4'h6: seg_of = 8'h82;  4'h7: seg_of = 8'hF8;
      4'h8: seg_of = 8'h80;  4'h9: seg_of = 8'h90;  4'hA: seg_of = 8'h88;  4'hB: seg_of = 8'h83;
      4'hC: seg_of = 8'hC6;  4'hD: seg_of = 8'hA1;  4'hE: seg_of = 8'h86;  default: seg_of = 8'h8E;
    endcase
  endfunction

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic [15:0]      map_q, map_d;
  db_state_t        db_state_q, db_state_d;
  logic [3:0]       db_cnt_q, db_cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  wr_state_t        wr_state_q, wr_state_d;
  logic [7:0]       digit_q [4];
  logic [7:0]       digit_d [4];
  logic             load_q, load_d;
  logic [1:0]       buf_q, buf_d;
  logic [7:0]       datai_q, datai_d;
  logic             pend_q, pend_d;
  logic [3:0]       pend_code_q, pend_code_d;

  logic [15:0] cur_map;
  logic        found, sample, scan_done, wr_go;
  logic [3:0]  found_idx, scan_code, db_run, wr_code;
  logic [1:0]  nxt_buf;

  always_comb begin
    // Scan timing; the press map accumulates one column per sample, bit index = row*4+col.
    sample    = (div_cnt_q == DIV_LAST);
    scan_done = sample && (col_idx_q == 2'd3);
    div_cnt_d = div_cnt_q + 1'b1;
    col_idx_d = col_idx_q;
    map_d     = map_q;
    cur_map   = map_q;
    for (int r = 0; r < 4; r++) cur_map[{2'(r), col_idx_q}] = ~row_sync_q[r];
    found     = 1'b0;
    found_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (cur_map[i]) begin
        found     = 1'b1;
        found_idx = 4'(i);
      end
    end
    if (sample) begin
      div_cnt_d = '0;
      col_idx_d = col_idx_q + 2'd1;
      map_d     = scan_done ? 16'h0000 : cur_map;
    end
    col_d     = ~(4'b0001 << col_idx_d);
    scan_code = key_of(found_idx);

    db_state_d  = db_state_q;
    db_cnt_d    = db_cnt_q;
    cand_d      = cand_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    db_run      = 4'd0;
    if (scan_done) begin
      if (db_state_q == DB_RELEASED) begin
        if (found) begin
          db_run = (db_cnt_q != 4'd0 && scan_code == cand_q) ? db_cnt_q + 4'd1 : 4'd1;
          cand_d = scan_code;
          if (db_run == DB_LAST) begin
            key_valid_d = 1'b1;
            key_code_d  = scan_code;
            db_state_d  = DB_PRESSED;
            db_cnt_d    = 4'd0;
          end else begin
            db_cnt_d = db_run;
          end
        end else begin
          db_cnt_d = 4'd0;
        end
      end else begin
        // Any key, even a different one, keeps the block in PRESSED.
        if (!found) begin
          db_run = db_cnt_q + 4'd1;
          if (db_run == DB_LAST) begin
            db_state_d = DB_RELEASED;
            db_cnt_d   = 4'd0;
          end else begin
            db_cnt_d = db_run;
          end
        end else begin
          db_cnt_d = 4'd0;
        end
      end
    end

    wr_state_d  = wr_state_q;
    digit_d     = digit_q;
    load_d      = 1'b0;
    buf_d       = buf_q;
    datai_d     = datai_q;
    pend_d      = pend_q;
    pend_code_d = pend_code_q;
    nxt_buf     = 2'd0;
    wr_go       = (wr_state_q == WR_IDLE) && (pend_q || key_valid_q);
    wr_code     = pend_q ? pend_code_q : key_code_q;
    if (wr_state_q == WR_IDLE) pend_d = 1'b0;
    // A pending slot freed this cycle can take the event that arrives alongside it.
    if (key_valid_q && !(wr_state_q == WR_IDLE && !pend_q)) begin
      if (!pend_q || wr_state_q == WR_IDLE) begin
        pend_d      = 1'b1;
        pend_code_d = key_code_q;
      end
    end
    case (wr_state_q)
      WR_INIT: wr_state_d = WR_WRITE;
      WR_WRITE: begin
        if (load_q && buf_q == 2'd3) begin
          wr_state_d = WR_IDLE;
        end else begin
          nxt_buf = load_q ? buf_q + 2'd1 : 2'd0;
          load_d  = 1'b1;
          buf_d   = nxt_buf;
          datai_d = digit_q[nxt_buf];
        end
      end
      default: begin
        if (wr_go) begin
          wr_state_d = WR_WRITE;
          load_d     = 1'b1;
          buf_d      = 2'd0;
`ifdef KEY_CLEAR_EN
          if (wr_code == 4'hF) begin
            for (int d = 0; d < 4; d++) digit_d[d] = 8'hFF;
            datai_d = 8'hFF;
          end else begin
            digit_d[3] = digit_q[2];
            digit_d[2] = digit_q[1];
            digit_d[1] = digit_q[0];
            digit_d[0] = seg_of(wr_code);
            datai_d    = seg_of(wr_code);
          end
`else
          digit_d[3] = digit_q[2];
          digit_d[2] = digit_q[1];
          digit_d[1] = digit_q[0];
          digit_d[0] = seg_of(wr_code);
          datai_d    = seg_of(wr_code);
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    row_meta_q <= row;
    row_sync_q <= row_meta_q;
    if (reset) begin
      div_cnt_q   <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      map_q       <= 16'h0000;
      db_state_q  <= DB_RELEASED;
      db_cnt_q    <= 4'd0;
      cand_q      <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      wr_state_q  <= WR_INIT;
      for (int d = 0; d < 4; d++) digit_q[d] <= 8'hFF;
      load_q      <= 1'b0;
      buf_q       <= 2'd0;
      datai_q     <= 8'hFF;
      pend_q      <= 1'b0;
      pend_code_q <= 4'd0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      map_q       <= map_d;
      db_state_q  <= db_state_d;
      db_cnt_q    <= db_cnt_d;
      cand_q      <= cand_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      wr_state_q  <= wr_state_d;
      digit_q     <= digit_d;
      load_q      <= load_d;
      buf_q       <= buf_d;
      datai_q     <= datai_d;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
    end
  end

  assign col        = col_q;
  assign load       = load_q;
  assign bufdestino = buf_q;
  assign datai      = datai_q;
  assign key_valid  = key_valid_q;
  assign key_code   = key_code_q;

endmodule
